// File: rtl/jstk2_pkg.sv
// Shared definitions for the PmodJSTK2 SPI responder: frame geometry,
// default LED opcode, packet layout and FSM states.
package jstk2_pkg;

  localparam int unsigned FRAME_BITS = 40;

  localparam int unsigned BYTE_X_LO = 0;
  localparam int unsigned BYTE_X_HI = 1;
  localparam int unsigned BYTE_Y_LO = 2;
  localparam int unsigned BYTE_Y_HI = 3;
  localparam int unsigned BYTE_BTNS = 4;

  localparam logic [7:0] LED_CMD_DEFAULT = 8'h84;

  // Declaration order equals transmit order: x_lo occupies the MSBs.
  typedef struct packed {
    logic [7:0] x_lo;
    logic [7:0] x_hi;
    logic [7:0] y_lo;
    logic [7:0] y_hi;
    logic [7:0] btns;
  } jstk2_pkt_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic jstk2_pkt_t build_pkt(input logic [9:0] x,
                                           input logic [9:0] y,
                                           input logic [1:0] b);
    jstk2_pkt_t p;
    p.x_lo = x[7:0];
    p.x_hi = {6'b0, x[9:8]};
    p.y_lo = y[7:0];
    p.y_hi = {6'b0, y[9:8]};
    p.btns = {6'b0, b};
    return p;
  endfunction

endpackage

// File: rtl/jstk2_spi_responder_if.sv
// SPI link between the joystick master and the responder.
interface jstk2_spi_responder_if;
  logic sclk;
  logic ss;
  logic mosi;
  logic miso;

  modport master (output sclk, output ss, output mosi, input miso);
  modport slave  (input sclk, input ss, input mosi, output miso);
endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input, followed by a
// single edge-detect register producing one-clk rise/fall strobes.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the raw input through the synchronizer and remember the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/jstk2_spi_responder.sv
// PmodJSTK2 emulator: SPI mode-0 slave returning a 5-byte position/button
// packet per SS-framed transfer. Optional set-LED command decode is enabled
// by defining JSTK2_LED_CMD_EN.
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  LED_CMD     = LED_CMD_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  jstk2_spi_responder_if.slave        spi,
  input  logic [9:0]                  x_pos,
  input  logic [9:0]                  y_pos,
  input  logic [1:0]                  btn,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic [23:0]                 led_rgb
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(spi.sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk(clk), .rst(rst), .d(spi.ss), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  logic sclk_level_unused;
  logic ss_level_unused;
  assign sclk_level_unused = sclk_s;
  assign ss_level_unused   = ss_s;

  state_t                  state, state_n;
  logic [FRAME_BITS-1:0]   tx_shift, tx_n;
  logic [5:0]              bit_cnt, cnt_n;
  logic                    miso_q, miso_n;
  logic                    done_n, err_n;

`ifdef JSTK2_LED_CMD_EN
  logic                    mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic [FRAME_BITS-1:0]   rx_shift, rx_n;
  logic [23:0]             led_q, led_n;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(spi.mosi), .q(mosi_s),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  assign led_rgb = led_q;
`else
  logic       mosi_unused;
  logic [7:0] led_cmd_unused;
  assign mosi_unused    = spi.mosi;
  assign led_cmd_unused = LED_CMD;
  assign led_rgb        = '0;
`endif

  assign spi.miso = miso_q;

  // Frame sequencing: snapshot on SS fall, shift on SCLK edges, close on SS rise.
  always_comb begin
    state_n = state;
    tx_n    = tx_shift;
    cnt_n   = bit_cnt;
    miso_n  = miso_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef JSTK2_LED_CMD_EN
    rx_n    = rx_shift;
    led_n   = led_q;
`endif
    unique case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (ss_fall) begin
          tx_n    = build_pkt(x_pos, y_pos, btn);
          miso_n  = tx_n[FRAME_BITS-1];
          cnt_n   = '0;
`ifdef JSTK2_LED_CMD_EN
          rx_n    = '0;
`endif
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        // SS rise takes priority over any coincident SCLK edge.
        if (ss_rise) begin
          state_n = IDLE;
          miso_n  = 1'b0;
          if (bit_cnt == 6'(FRAME_BITS)) begin
            done_n = 1'b1;
`ifdef JSTK2_LED_CMD_EN
            if (rx_shift[39:32] == LED_CMD) led_n = rx_shift[31:8];
`endif
          end else begin
            err_n = 1'b1;
          end
        end else if (sclk_rise) begin
`ifdef JSTK2_LED_CMD_EN
          rx_n  = {rx_shift[FRAME_BITS-2:0], mosi_s};
`endif
          cnt_n = (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
        end else if (sclk_fall) begin
          // Zero fill drives miso low once all 40 bits have left.
          tx_n   = {tx_shift[FRAME_BITS-2:0], 1'b0};
          miso_n = tx_n[FRAME_BITS-1];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_shift   <= '0;
      bit_cnt    <= '0;
      miso_q     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
`ifdef JSTK2_LED_CMD_EN
      rx_shift   <= '0;
      led_q      <= '0;
`endif
    end else begin
      state      <= state_n;
      tx_shift   <= tx_n;
      bit_cnt    <= cnt_n;
      miso_q     <= miso_n;
      frame_done <= done_n;
      frame_err  <= err_n;
`ifdef JSTK2_LED_CMD_EN
      rx_shift   <= rx_n;
      led_q      <= led_n;
`endif
    end
  end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Directed bench for jstk2_spi_responder; MISO bits are scoreboarded from a
// bench-side packet model. LED checks adapt to JSTK2_LED_CMD_EN.
module tb_jstk2_spi_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x_pos, y_pos;
  logic [1:0]  btn;
  logic        frame_done, frame_err;
  logic [23:0] led_rgb;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int err_seen = 0;
  logic exp_q[$];
  bit skip;

  jstk2_spi_responder_if spi ();

  jstk2_spi_responder #(.SYNC_STAGES(2), .LED_CMD(8'h84)) dut (
    .clk(clk), .rst(rst), .spi(spi),
    .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
    .frame_done(frame_done), .frame_err(frame_err), .led_rgb(led_rgb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_seen++;
    if (frame_err) err_seen++;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] model(input logic [9:0] x, input logic [9:0] y, input logic [1:0] b);
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 6'b0, b};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_miso"},  40'(spi.miso),   40'd0);
    check({name, "_done"},  40'(frame_done), 40'd0);
    check({name, "_err"},   40'(frame_err),  40'd0);
    check({name, "_led"},   40'(led_rgb),    40'd0);
  endtask

  task automatic run_frame(input int nbits, input logic [39:0] mo, input int chg_bit,
                           input logic [9:0] chg_x, input int rst_bit,
                           input int exp_done, input int exp_err, input string name);
    int d0, e0;
    logic [39:0] pkt;
    logic exp_b, tail;
    pkt = model(x_pos, y_pos, btn);
    for (int i = 0; i < nbits; i++) exp_q.push_back(i < 40 ? pkt[39-i] : 1'b0);
    tail = (nbits < 40) ? pkt[39-nbits] : 1'b0;
    skip = 1'b0;
    d0 = done_seen;
    e0 = err_seen;
    spi.ss = 1'b0;
    cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi.mosi = (i < 40) ? mo[39-i] : 1'b0;
      if (!skip) begin
        exp_b = exp_q.pop_front();
        check($sformatf("%s_miso_bit%0d", name, i), 40'(spi.miso), 40'(exp_b));
      end
      spi.sclk = 1'b1;
      cyc(HALF);
      spi.sclk = 1'b0;
      if (i == chg_bit) x_pos = chg_x;
      if (i == rst_bit) begin
        rst = 1'b1;
        cyc(2);
        check_reset_vals({name, "_midrst"});
        rst = 1'b0;
        exp_q.delete();
        skip = 1'b1;
      end
      cyc(HALF);
    end
    check({name, "_queue_empty"}, 40'(exp_q.size()), 40'd0);
    spi.ss = 1'b1;
    cyc(2);
    check({name, "_miso_pre_ss"}, 40'(spi.miso), skip ? 40'd0 : 40'(tail));
    cyc(1);
    check({name, "_miso_post_ss"}, 40'(spi.miso), 40'd0);
    cyc(10);
    check({name, "_done_pulses"}, 40'(done_seen - d0), 40'(exp_done));
    check({name, "_err_pulses"},  40'(err_seen - e0),  40'(exp_err));
  endtask

  initial begin
    logic [23:0] led_exp;
    rst = 1'b1;
    spi.sclk = 1'b0;
    spi.ss = 1'b1;
    spi.mosi = 1'b0;
    x_pos = 10'h2A5;
    y_pos = 10'h13C;
    btn = 2'b10;
    cyc(4);
    check_reset_vals("reset");
    rst = 1'b0;
    cyc(4);

    // Basic frame: A5,02,3C,01,02.
    run_frame(40, 40'h0, -1, 10'h0, -1, 1, 0, "basic");
    check("basic_led", 40'(led_rgb), 40'd0);

    // x changes after bit 5: current frame keeps the snapshot.
    run_frame(40, 40'h0, 5, 10'h3FF, -1, 1, 0, "snap");
    run_frame(40, 40'h0, -1, 10'h0, -1, 1, 0, "newx");

    // Abort after 17 bits; y chosen so the pending MISO bit is 1.
    y_pos = 10'h1FF;
    run_frame(17, 40'h0, -1, 10'h0, -1, 0, 1, "abort");
    y_pos = 10'h13C;
    x_pos = 10'h2A5;

`ifdef JSTK2_LED_CMD_EN
    led_exp = 24'h112233;
`else
    led_exp = 24'h000000;
`endif
    run_frame(40, 40'h8411223300, -1, 10'h0, -1, 1, 0, "ledcmd");
    check("ledcmd_led", 40'(led_rgb), 40'(led_exp));
    run_frame(40, 40'h85AABBCC00, -1, 10'h0, -1, 1, 0, "ledother");
    check("ledother_led", 40'(led_rgb), 40'(led_exp));

    // Reset mid-frame, then a clean frame.
    btn = 2'b01;
    run_frame(40, 40'h8411223300, -1, 10'h0, 20, 0, 0, "rstframe");
    check_reset_vals("after_rst");
    run_frame(40, 40'h0, -1, 10'h0, -1, 1, 0, "postrst");

    // Overlong window: trailing bits are zero and the frame is flagged.
    run_frame(45, 40'h0, -1, 10'h0, -1, 0, 1, "long45");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
